// File: rtl/vga_fb_arbiter_if.sv
// CPU write handshake and single-port framebuffer RAM bus shared by the VGA arbiter.
// master = CPU/RAM side, slave = arbiter side.
interface vga_fb_arbiter_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [8:0]  wr_data;
    logic        wr_err;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [8:0]  mem_wdata;
    logic [8:0]  mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, wr_err, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, wr_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: video scan-out reads always win, queued CPU writes drain in blanking.
// Read data is registered into rgb two cycles after the pixel coordinates, syncs delayed to match.
module vga_fb_arbiter #(
    parameter int unsigned FB_WIDTH    = 160,
    parameter int unsigned FB_HEIGHT   = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                video_enable,
    input  logic [9:0]                          pixel_x,
    input  logic [9:0]                          pixel_y,
    input  logic                                hsync_in,
    input  logic                                vsync_in,
    vga_fb_arbiter_if.slave                     bus,
    output logic [8:0]                          rgb,
    output logic                                hsync,
    output logic                                vsync,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] FB_CELLS = 16'(FB_WIDTH * FB_HEIGHT);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_READ,
        PORT_WRITE
    } port_mode_e;

    port_mode_e       mode;

    logic [14:0]      q_addr [FIFO_DEPTH];
    logic [8:0]       q_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;

    logic             accept;
    logic             in_range;
    logic             push;
    logic             pop;

    logic [14:0]      rd_addr;
    logic [14:0]      hold_addr;
    logic [8:0]       hold_wdata;

    logic             en_d1;
    logic [1:0]       hs_pipe;
    logic [1:0]       vs_pipe;

    assign fifo_level   = level;
    assign bus.wr_ready = (level != LVL_FULL);
    assign accept       = bus.wr_valid && bus.wr_ready;
    assign in_range     = ({1'b0, bus.wr_addr} < FB_CELLS);
    assign push         = accept && in_range;

    assign rd_addr = 15'(((32'(pixel_y) >> SCALE_SHIFT) * 32'(FB_WIDTH))
                       + (32'(pixel_x) >> SCALE_SHIFT));

    // Port owner is decided fresh every cycle; reset forces idle so the held (cleared) bus shows.
    always_comb begin
        mode = PORT_IDLE;
        if (!reset) begin
            mode = PORT_IDLE;
        end else if (video_enable) begin
            mode = PORT_READ;
        end else if (level != '0) begin
            mode = PORT_WRITE;
        end
    end

    assign pop = (mode == PORT_WRITE);

    always_comb begin
        bus.mem_addr  = hold_addr;
        bus.mem_wdata = hold_wdata;
        bus.mem_we    = 1'b0;
        case (mode)
            PORT_READ: begin
                bus.mem_addr = rd_addr;
            end
            PORT_WRITE: begin
                bus.mem_addr  = q_addr[rd_ptr];
                bus.mem_wdata = q_data[rd_ptr];
                bus.mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.wr_addr;
            q_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            bus.wr_err <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            bus.wr_err <= accept && !in_range;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // Idle cycles keep showing whatever the bus last carried.
            if (mode != PORT_IDLE) begin
                hold_addr <= bus.mem_addr;
            end
            if (mode == PORT_WRITE) begin
                hold_wdata <= bus.mem_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_d1   <= 1'b0;
            rgb     <= '0;
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            en_d1   <= video_enable;
            rgb     <= en_d1 ? bus.mem_rdata : '0;
            hs_pipe <= {hs_pipe[0], hsync_in};
            vs_pipe <= {vs_pipe[0], vsync_in};
        end
    end

    assign hsync = hs_pipe[1];
    assign vsync = vs_pipe[1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: blanking writes, scan-out reads, queue full/wrap,
// out-of-range rejection and mid-burst reset, each compared against hand-computed values.
module tb_vga_fb_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       video_enable = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [8:0] rgb;
    logic       hsync;
    logic       vsync;
    logic [2:0] fifo_level;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(
        .FB_WIDTH    (160),
        .FB_HEIGHT   (120),
        .SCALE_SHIFT (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .video_enable (video_enable),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .bus          (bus),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync),
        .fifo_level   (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.mem_rdata = '0;

        // Reset state
        #1 reset = 1'b0;
        #1;
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h1);
        check("rst_vsync", 32'(vsync), 32'h1);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_wr_err", 32'(bus.wr_err), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("post_rst_ready", 32'(bus.wr_ready), 32'h1);
        cyc();
        cyc();

        // Blanking write: addr 5 data 1AB
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 15'd5;
        bus.wr_data  = 9'h1AB;
        #1;
        check("bw_no_bypass_we", 32'(bus.mem_we), 32'h0);
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        check("bw_level1", 32'(fifo_level), 32'h1);
        check("bw_we", 32'(bus.mem_we), 32'h1);
        check("bw_addr", 32'(bus.mem_addr), 32'd5);
        check("bw_wdata", 32'(bus.mem_wdata), 32'h1AB);
        cyc();
        check("bw_level0", 32'(fifo_level), 32'h0);
        check("bw_idle_we", 32'(bus.mem_we), 32'h0);
        check("bw_hold_addr", 32'(bus.mem_addr), 32'd5);
        check("bw_hold_wdata", 32'(bus.mem_wdata), 32'h1AB);

        // Active read: (6>>2)*160 + (9>>2) = 162
        video_enable = 1'b1;
        pixel_x = 10'd9;
        pixel_y = 10'd6;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #1;
        check("rd_addr_162", 32'(bus.mem_addr), 32'd162);
        check("rd_we", 32'(bus.mem_we), 32'h0);
        cyc();
        video_enable = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        bus.mem_rdata = 9'h0C5;
        check("rd_rgb_edge1", 32'(rgb), 32'h0);
        check("rd_hsync_edge1", 32'(hsync), 32'h0);
        check("rd_vsync_edge1", 32'(vsync), 32'h0);
        cyc();
        check("rd_rgb_edge2", 32'(rgb), 32'h0C5);
        check("rd_hsync_edge2", 32'(hsync), 32'h1);
        check("rd_vsync_edge2", 32'(vsync), 32'h1);
        cyc();
        check("rd_rgb_blank", 32'(rgb), 32'h0);
        check("rd_hsync_edge3", 32'(hsync), 32'h0);
        check("rd_idle_hold_addr", 32'(bus.mem_addr), 32'd162);

        // Address mapping corners: last cell 19199, and 15-bit truncation 41055 -> 8287
        video_enable = 1'b1;
        pixel_x = 10'd639;
        pixel_y = 10'd479;
        #1;
        check("rd_addr_last", 32'(bus.mem_addr), 32'd19199);
        pixel_x = 10'd1023;
        pixel_y = 10'd1023;
        #1;
        check("rd_addr_trunc", 32'(bus.mem_addr), 32'd8287);
        pixel_x = 10'd3;
        pixel_y = 10'd3;
        #1;
        check("rd_addr_zero", 32'(bus.mem_addr), 32'd0);
        cyc();

        // Full queue during active video: 5 pushes, only 4 accepted
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(100 + i);
            bus.wr_data  = 9'(16 + i);
            #1;
            check("full_ready", 32'(bus.wr_ready), (i < 4) ? 32'h1 : 32'h0);
            cyc();
            check("full_level", 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
            check("full_no_we", 32'(bus.mem_we), 32'h0);
        end
        bus.wr_valid = 1'b0;
        cyc();
        check("full_hold_we", 32'(bus.mem_we), 32'h0);
        check("full_hold_level", 32'(fifo_level), 32'd4);
        video_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_we", 32'(bus.mem_we), 32'h1);
            check("drain_addr", 32'(bus.mem_addr), 32'(100 + i));
            check("drain_wdata", 32'(bus.mem_wdata), 32'(16 + i));
            check("drain_level", 32'(fifo_level), 32'(4 - i));
            cyc();
        end
        #1;
        check("drain_done_level", 32'(fifo_level), 32'h0);
        check("drain_done_we", 32'(bus.mem_we), 32'h0);
        cyc();

        // Out-of-range write (19200) rejected, then boundary 19199 accepted
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 15'd19200;
        bus.wr_data  = 9'h0AA;
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        check("oor_err", 32'(bus.wr_err), 32'h1);
        check("oor_level", 32'(fifo_level), 32'h0);
        check("oor_we", 32'(bus.mem_we), 32'h0);
        cyc();
        check("oor_err_clear", 32'(bus.wr_err), 32'h0);
        check("oor_still_no_we", 32'(bus.mem_we), 32'h0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 15'd19199;
        bus.wr_data  = 9'h1FF;
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        check("edge_no_err", 32'(bus.wr_err), 32'h0);
        check("edge_level", 32'(fifo_level), 32'h1);
        check("edge_addr", 32'(bus.mem_addr), 32'd19199);
        cyc();
        check("edge_drained", 32'(fifo_level), 32'h0);

        // Simultaneous push+pop at level 2 across 8 operations (pointers wrap twice)
        video_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(200 + i);
            bus.wr_data  = 9'(32 + i);
            cyc();
        end
        check("sim_level2", 32'(fifo_level), 32'd2);
        video_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.wr_addr = 15'(202 + i);
            bus.wr_data = 9'(34 + i);
            #1;
            check("sim_addr", 32'(bus.mem_addr), 32'(200 + i));
            check("sim_wdata", 32'(bus.mem_wdata), 32'(32 + i));
            cyc();
            check("sim_level", 32'(fifo_level), 32'd2);
        end
        bus.wr_valid = 1'b0;
        #1;
        check("sim_tail0_addr", 32'(bus.mem_addr), 32'd208);
        cyc();
        check("sim_tail1_addr", 32'(bus.mem_addr), 32'd209);
        check("sim_tail1_level", 32'(fifo_level), 32'd1);
        cyc();
        check("sim_empty", 32'(fifo_level), 32'd0);

        // Reset mid-burst at level 3
        video_enable = 1'b1;
        bus.mem_rdata = 9'h155;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(300 + i);
            bus.wr_data  = 9'(48 + i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        check("mb_level3", 32'(fifo_level), 32'd3);
        check("mb_rgb_pre", 32'(rgb), 32'h155);
        check("mb_hsync_pre", 32'(hsync), 32'h0);
        reset = 1'b0;
        #1;
        check("mb_rgb", 32'(rgb), 32'h0);
        check("mb_level", 32'(fifo_level), 32'h0);
        check("mb_hsync", 32'(hsync), 32'h1);
        check("mb_vsync", 32'(vsync), 32'h1);
        check("mb_mem_addr", 32'(bus.mem_addr), 32'h0);
        cyc();
        video_enable = 1'b0;
        reset = 1'b1;
        #1;
        check("mb_release_we", 32'(bus.mem_we), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mb_no_stale_we", 32'(bus.mem_we), 32'h0);
            check("mb_ready", 32'(bus.wr_ready), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_WIDTH, default 160, framebuffer columns.
REQ-002 Parameter FB_HEIGHT, default 120, framebuffer rows.
REQ-003 Parameter SCALE_SHIFT, default 2, screen-to-framebuffer downscale as log2 (4x4 screen pixels per framebuffer cell).
REQ-004 Parameter FIFO_DEPTH, default 4, write-queue entries (power of two).
REQ-005 clock  in  1  pixel clock, the sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 video_enable  in  1  active-area flag from sync generator.
REQ-008 pixel_x  in  10  current screen column.
REQ-009 pixel_y  in  10  current screen row.
REQ-010 hsync_in / vsync_in  in  1 each  raw sync pulses from sync generator.
REQ-011 wr_valid  in  1  CPU write request.
REQ-012 wr_ready  out  1  write queue can accept.
REQ-013 wr_addr  in  15  framebuffer word address.
REQ-014 wr_data  in  9  RGB 3:3:3 word.
REQ-015 wr_err  out  1  one-cycle pulse: accepted write discarded (address out of range).
REQ-016 mem_addr  out  15  RAM address; mem_we  out  1; mem_wdata  out  9.
REQ-017 mem_rdata  in  9  RAM read data, valid one cycle after address (synchronous RAM).
REQ-018 rgb  out  9  pixel colour; hsync / vsync  out  1 each  syncs aligned to rgb.
REQ-019 fifo_level  out  3  queued-write count, 0..FIFO_DEPTH.

Function
REQ-020 Handshake: write accepted on a rising edge with wr_valid=1 and wr_ready=1; wr_ready = (fifo_level != FIFO_DEPTH), no same-cycle bypass of a full queue.
REQ-021 Accepted write with wr_addr >= FB_WIDTH*FB_HEIGHT (19200) not enqueued; wr_err=1 the following cycle.
REQ-022 Port scheduling is combinational each cycle, strict priority: (1) video_enable=1 -> read; (2) else queue non-empty -> write queue head; (3) else idle.
REQ-023 Read: mem_addr = (pixel_y>>SCALE_SHIFT)*FB_WIDTH + (pixel_x>>SCALE_SHIFT), truncated to 15 bits; mem_we=0.
REQ-024 Write: mem_addr/mem_wdata = head entry, mem_we=1; head popped on that edge.
REQ-025 Idle: mem_we=0; mem_addr and mem_wdata held at last driven value.
REQ-026 At most one pop per cycle; simultaneous push and pop leaves fifo_level unchanged; writes never issued while video_enable=1.
REQ-027 A write enqueued into an empty queue issues no earlier than the following cycle.
REQ-028 Queue order strictly FIFO; read-pointer and write-pointer wrap modulo FIFO_DEPTH.
REQ-029 video_enable delayed two stages (en_d1, en_d2); rgb <= en_d1 ? mem_rdata : 0, so rgb lags pixel_x/pixel_y by 2 cycles.
REQ-030 hsync/vsync = hsync_in/vsync_in delayed by exactly 2 registers.
REQ-031 Read and write addresses use the same mapping; a write issued in blanking is visible from the next active pixel referencing it.

Reset
REQ-032 reset=0 asynchronously clears: queue (fifo_level=0, pointers 0), rgb=0, en_d1=en_d2=0, wr_err=0, mem_addr=0, mem_wdata=0; hsync, vsync and both delay stages = 1.
REQ-033 Reset asserted mid-operation discards queued writes; no write issues in the cycle reset releases.
REQ-034 wr_ready=1 from the first edge after reset release.

Verification
REQ-035 Blanking write: video_enable=0, push addr 5 data 9'h1AB -> next cycle mem_we=1, mem_addr=5, mem_wdata=9'h1AB, fifo_level back to 0.
REQ-036 Active read: video_enable=1, pixel_x=9, pixel_y=6 -> mem_addr=162, mem_we=0; rgb equals mem_rdata two edges later; hsync/vsync delayed 2 edges.
REQ-037 Full queue: 5 pushes during active video -> first 4 accepted, wr_ready=0 at level 4, no mem_we until video_enable=0, then 4 writes on 4 consecutive cycles in push order.
REQ-038 Out-of-range: push addr 19200 -> wr_err pulses 1 cycle, fifo_level unchanged, no mem_we.
REQ-039 Simultaneous: level 2, blanking, push + pop same edge -> level stays 2, pointers wrap correctly across 8 operations.
REQ-040 Reset mid-burst: level 3, reset=0 -> rgb=0, fifo_level=0, hsync=vsync=1 immediately; queued writes never issue.
